// File: rtl/risc_datapath.sv
// VeriRisc datapath: instruction register, program counter, accumulator, ALU,
// address multiplexer and retired-instruction counter. It sits downstream of the
// sequence controller and closes the fetch/execute loop by returning opcode and zero.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel   controller strobes
//   data_in             memory read data
//   opcode, zero        IR opcode field and ACC==0 flag, back to the controller
//   addr                memory address (PC when sel=1, IR operand when sel=0)
//   data_out, data_oe   write data (ACC) and data bus drive enable
//   mem_rd, mem_wr      memory strobes
//   acc_out, pc_out     debug views of ACC and PC
//   icount              saturating count of instruction fetches (ld_ir pulses)

module risc_datapath #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              ld_ir,
  input  logic              ld_acc,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              halt,
  input  logic              data_e,
  input  logic              sel,
  input  logic [DWIDTH-1:0] data_in,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] acc_out,
  output logic [AWIDTH-1:0] pc_out,
  output logic [CWIDTH-1:0] icount
);

  typedef enum logic [2:0] {
    OpHlt = 3'd0,
    OpSkz = 3'd1,
    OpAdd = 3'd2,
    OpAnd = 3'd3,
    OpXor = 3'd4,
    OpLda = 3'd5,
    OpSto = 3'd6,
    OpJmp = 3'd7
  } opcode_e;

  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [CWIDTH-1:0] icount_q, icount_d;
  logic [DWIDTH-1:0] alu_result;
  opcode_e           op;

  assign op = opcode_e'(ir_q[DWIDTH-1:DWIDTH-3]);

  // ALU works off the registered IR, so a simultaneous ld_ir/ld_acc executes the
  // instruction already held in IR while the new one is captured.
  always_comb begin
    alu_result = acc_q;
    case (op)
      OpAdd:   alu_result = acc_q + data_in;  // carry out discarded by truncation
      OpAnd:   alu_result = acc_q & data_in;
      OpXor:   alu_result = acc_q ^ data_in;
      OpLda:   alu_result = data_in;
      default: alu_result = acc_q;            // HLT, SKZ, STO, JMP pass ACC
    endcase
  end

  // Next-state logic; halt freezes every register regardless of other strobes.
  always_comb begin
    ir_d     = ir_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    icount_d = icount_q;
    if (!halt) begin
      if (ld_ir) begin
        ir_d = data_in;
        if (icount_q != {CWIDTH{1'b1}}) begin
          icount_d = icount_q + CWIDTH'(1);
        end
      end
      if (ld_pc) begin
        pc_d = ir_q[AWIDTH-1:0];
      end else if (inc_pc) begin
        pc_d = pc_q + AWIDTH'(1);             // wraps naturally at 2^AWIDTH
      end
      if (ld_acc) begin
        acc_d = alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q     <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      icount_q <= '0;
    end else begin
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      icount_q <= icount_d;
    end
  end

  assign opcode   = ir_q[DWIDTH-1:DWIDTH-3];
  assign zero     = (acc_q == '0);            // from the register, not the ALU
  assign addr     = sel ? pc_q : ir_q[AWIDTH-1:0];
  assign data_out = acc_q;
  assign acc_out  = acc_q;
  assign pc_out   = pc_q;
  assign icount   = icount_q;

  // Strobes are gated by reset so memory sees nothing while the core is held.
  assign data_oe = data_e & rst;
  assign mem_rd  = rd & rst;
  assign mem_wr  = wr & ~halt & rst;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed scenarios plus randomized
// strobes checked against an instruction-level reference model.

module tb_risc_datapath;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;

  // Strobe bit positions in the packed stimulus word.
  localparam int BRD = 0, BWR = 1, BLDIR = 2, BLDACC = 3, BLDPC = 4;
  localparam int BINC = 5, BHALT = 6, BDE = 7, BSEL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel;
  logic [DW-1:0] data_in;
  logic [2:0]    opcode;
  logic          zero;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_oe, mem_rd, mem_wr;
  logic [DW-1:0] acc_out;
  logic [AW-1:0] pc_out;
  logic [CW-1:0] icount;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_ir, m_pc, m_acc, m_cnt;

  risc_datapath #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .ld_ir    (ld_ir),
    .ld_acc   (ld_acc),
    .ld_pc    (ld_pc),
    .inc_pc   (inc_pc),
    .halt     (halt),
    .data_e   (data_e),
    .sel      (sel),
    .data_in  (data_in),
    .opcode   (opcode),
    .zero     (zero),
    .addr     (addr),
    .data_out (data_out),
    .data_oe  (data_oe),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .acc_out  (acc_out),
    .pc_out   (pc_out),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  function automatic int model_alu(int op, int acc, int din);
    case (op)
      2:       return (acc + din) % 256;
      3:       return acc & din;
      4:       return acc ^ din;
      5:       return din;
      default: return acc;
    endcase
  endfunction

  task automatic model_reset();
    m_ir = 0; m_pc = 0; m_acc = 0; m_cnt = 0;
  endtask

  // Drive strobes, clock one edge, advance the model, settle 1 ns past the edge.
  task automatic step(input logic [8:0] s, input logic [DW-1:0] din);
    int old_ir;
    {sel, data_e, halt, inc_pc, ld_pc, ld_acc, ld_ir, wr, rd} = s;
    data_in = din;
    @(posedge clk);
    old_ir = m_ir;
    if (!s[BHALT]) begin
      if (s[BLDACC]) m_acc = model_alu(old_ir / 32, m_acc, int'(din));
      if (s[BLDIR]) begin
        m_ir = int'(din);
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (s[BLDPC]) m_pc = old_ir % 32;
      else if (s[BINC]) m_pc = (m_pc + 1) % 32;
    end
    #1;
  endtask

  task automatic idle();
    step(9'b0, 8'h00);
  endtask

  task automatic apply_reset();
    {sel, data_e, halt, inc_pc, ld_pc, ld_acc, ld_ir, wr, rd} = 9'b0;
    data_in = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (acc_out !== 8'h00) begin failures++; $display("FAIL init_acc got=%h exp=00", acc_out); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL init_zero got=%b exp=1", zero); end
    checks++; if (icount !== 16'h0) begin failures++; $display("FAIL init_icount got=%h exp=0", icount); end
    // Build ACC=0x5A, PC=7, then pull reset mid-cycle.
    step(9'b1 << BLDIR, 8'hA7);
    step((9'b1 << BLDACC) | (9'b1 << BLDPC), 8'h5A);
    checks++; if (acc_out !== 8'h5A || pc_out !== 5'd7) begin
      failures++; $display("FAIL pre_reset acc=%h pc=%0d exp acc=5a pc=7", acc_out, pc_out);
    end
    {sel, data_e, halt, inc_pc, ld_pc, ld_acc, ld_ir, wr, rd} = 9'b0;
    wr = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (acc_out !== 8'h00 || pc_out !== 5'd0 || opcode !== 3'd0) begin
      failures++; $display("FAIL async_reset acc=%h pc=%0d op=%0d exp all 0", acc_out, pc_out, opcode);
    end
    checks++; if (zero !== 1'b1 || icount !== 16'h0 || mem_wr !== 1'b0 || addr !== 5'd0) begin
      failures++; $display("FAIL async_reset_misc zero=%b icnt=%h mem_wr=%b addr=%0d exp 1,0,0,0",
                           zero, icount, mem_wr, addr);
    end
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch_lda_add();
    step(9'b1 << BLDIR, 8'hA3);
    checks++; if (opcode !== 3'd5 || addr !== 5'd3) begin
      failures++; $display("FAIL fetch op=%0d addr=%0d exp op=5 addr=3", opcode, addr);
    end
    step(9'b1 << BLDACC, 8'h7F);
    checks++; if (acc_out !== 8'h7F || zero !== 1'b0) begin
      failures++; $display("FAIL lda acc=%h zero=%b exp 7f 0", acc_out, zero);
    end
    step(9'b1 << BLDIR, 8'h44);
    step(9'b1 << BLDACC, 8'h81);
    checks++; if (acc_out !== 8'h00 || zero !== 1'b1) begin
      failures++; $display("FAIL add_carry acc=%h zero=%b exp 00 1", acc_out, zero);
    end
  endtask

  task automatic test_logic_ops();
    step(9'b1 << BLDIR, 8'hA0);
    step(9'b1 << BLDACC, 8'hF0);
    step(9'b1 << BLDIR, 8'h60);
    step(9'b1 << BLDACC, 8'h3C);
    checks++; if (acc_out !== 8'h30) begin failures++; $display("FAIL and acc=%h exp 30", acc_out); end
    step(9'b1 << BLDIR, 8'h80);
    step(9'b1 << BLDACC, 8'h30);
    checks++; if (acc_out !== 8'h00 || zero !== 1'b1) begin
      failures++; $display("FAIL xor acc=%h zero=%b exp 00 1", acc_out, zero);
    end
    step(9'b1 << BLDIR, 8'hA0);
    step(9'b1 << BLDACC, 8'h55);
    step(9'b1 << BLDIR, 8'hC0);
    step(9'b1 << BLDACC, 8'hFF);
    checks++; if (acc_out !== 8'h55 || data_out !== 8'h55) begin
      failures++; $display("FAIL sto acc=%h data_out=%h exp 55", acc_out, data_out);
    end
    // Simultaneous load: ALU runs LDA (old IR), IR captures the new word.
    step(9'b1 << BLDIR, 8'hA0);
    step((9'b1 << BLDIR) | (9'b1 << BLDACC), 8'h47);
    checks++; if (acc_out !== 8'h47 || opcode !== 3'd2) begin
      failures++; $display("FAIL ir_acc_same acc=%h op=%0d exp 47 2", acc_out, opcode);
    end
  endtask

  task automatic test_pc();
    step(9'b1 << BLDIR, 8'hFF);
    step(9'b1 << BLDPC, 8'h00);
    checks++; if (pc_out !== 5'd31) begin failures++; $display("FAIL pc_load got=%0d exp 31", pc_out); end
    step(9'b1 << BINC, 8'h00);
    checks++; if (pc_out !== 5'd0) begin failures++; $display("FAIL pc_wrap got=%0d exp 0", pc_out); end
    step(9'b1 << BLDIR, 8'hFD);
    step((9'b1 << BLDPC) | (9'b1 << BINC) | (9'b1 << BSEL), 8'h00);
    checks++; if (pc_out !== 5'd29 || addr !== 5'd29) begin
      failures++; $display("FAIL pc_prio pc=%0d addr=%0d exp 29", pc_out, addr);
    end
  endtask

  task automatic test_halt();
    logic [7:0] acc0;
    logic [4:0] pc0;
    logic [2:0] op0;
    logic [15:0] cnt0;
    acc0 = acc_out; pc0 = pc_out; op0 = opcode; cnt0 = icount;
    step((9'b1 << BHALT) | (9'b1 << BLDACC) | (9'b1 << BLDIR) | (9'b1 << BINC) |
         (9'b1 << BWR) | (9'b1 << BRD) | (9'b1 << BDE), 8'h5B);
    checks++; if (acc_out !== acc0 || pc_out !== pc0 || opcode !== op0 || icount !== cnt0) begin
      failures++; $display("FAIL halt_hold acc=%h pc=%0d op=%0d cnt=%h exp %h %0d %0d %h",
                           acc_out, pc_out, opcode, icount, acc0, pc0, op0, cnt0);
    end
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || data_oe !== 1'b1) begin
      failures++; $display("FAIL halt_strobes wr=%b rd=%b oe=%b exp 0 1 1", mem_wr, mem_rd, data_oe);
    end
  endtask

  task automatic test_random();
    logic [8:0] s;
    logic [7:0] d;
    int exp_addr;
    for (int i = 0; i < 400; i++) begin
      s = 9'($urandom);
      s[BHALT] = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      step(s, d);
      exp_addr = s[BSEL] ? m_pc : m_ir % 32;
      checks++;
      if (int'(acc_out) != m_acc || int'(pc_out) != m_pc || int'(opcode) != m_ir / 32 ||
          int'(icount) != m_cnt || zero !== (m_acc == 0) || int'(addr) != exp_addr ||
          data_out !== acc_out) begin
        failures++;
        $display("FAIL rand_state[%0d] acc=%h pc=%0d op=%0d cnt=%0d addr=%0d exp %h %0d %0d %0d %0d",
                 i, acc_out, pc_out, opcode, icount, addr, m_acc, m_pc, m_ir / 32, m_cnt, exp_addr);
      end
      checks++;
      if (mem_rd !== s[BRD] || data_oe !== s[BDE] || mem_wr !== (s[BWR] & ~s[BHALT])) begin
        failures++;
        $display("FAIL rand_strobe[%0d] rd=%b oe=%b wr=%b exp %b %b %b", i, mem_rd, data_oe,
                 mem_wr, s[BRD], s[BDE], s[BWR] & ~s[BHALT]);
      end
    end
  endtask

  task automatic test_icount_sat();
    apply_reset();
    for (int i = 0; i < 65535; i++) step(9'b1 << BLDIR, 8'(i));
    checks++; if (icount !== 16'hFFFF || int'(icount) != m_cnt) begin
      failures++; $display("FAIL icount_full got=%h exp ffff", icount);
    end
    step(9'b1 << BLDIR, 8'h12);
    checks++; if (icount !== 16'hFFFF) begin
      failures++; $display("FAIL icount_sat got=%h exp ffff", icount);
    end
    checks++; if (opcode !== 3'd0 || addr !== 5'd18) begin
      failures++; $display("FAIL icount_ir op=%0d addr=%0d exp 0 18", opcode, addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    {sel, data_e, halt, inc_pc, ld_pc, ld_acc, ld_ir, wr, rd} = 9'b0;
    data_in = '0;
    model_reset();
    test_reset();
    test_fetch_lda_add();
    test_logic_ops();
    test_pc();
    test_halt();
    test_random();
    test_icount_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
